mem_pic_arb: RTL and testbench

// - Two-port read arbiter sharing the single synchronous read port of mem_pic.
// - Port 0 = CPU load path (pipelined core, MEM stage); port 1 = picture streamer/display reader.
// - Accepts at most one request per cycle. Drives mem_pic ADDRESS. Returns READ data to the

---
 rtl/mem_pic_arb_if.sv | 49 ++++
 rtl/mem_pic_arb.sv | 146 ++++++++++++++
 tb/tb_mem_pic_arb.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_pic_arb_if.sv
`default_nettype none
// ============================================================================
// Module     : mem_pic_arb_if
// Description: Bundle of the two request/response ports of the mem_pic read
//              arbiter together with the mem_pic address/read-data pair.
//              The master side is the requesters plus the memory model; the
//              slave side is the arbiter itself.
// Revision   : 1.0 - initial release
// ============================================================================
interface mem_pic_arb_if #(
    parameter int SIZE = 8
);
    // Port 0: CPU load path
    logic            req0_valid;
    logic [SIZE-1:0] req0_addr;
    logic            req0_ready;
    logic            rsp0_valid;
    logic [SIZE-1:0] rsp0_data;

    // Port 1: picture streamer
    logic            req1_valid;
    logic [SIZE-1:0] req1_addr;
    logic            req1_ready;
    logic            rsp1_valid;
    logic [SIZE-1:0] rsp1_data;

    // Shared synchronous read port of mem_pic
    logic [SIZE-1:0] mem_address;
    logic [SIZE-1:0] mem_read;

    modport master (
        output req0_valid, req0_addr,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_address,
        output mem_read
    );

    modport slave (
        input  req0_valid, req0_addr,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_address,
        input  mem_read
    );
endinterface
`default_nettype wire

// File: rtl/mem_pic_arb.sv
`default_nettype none
// ============================================================================
// Module     : mem_pic_arb
// Description: Two-port read arbiter in front of the single synchronous read
//              port of mem_pic. Port 0 is the CPU load path, port 1 the
//              picture streamer. One request is accepted per cycle; read data
//              returns three edges after acceptance, strictly in order.
//              Optional macro MEM_PIC_ARB_RR_EN selects round-robin
//              arbitration; otherwise port 0 has fixed priority with a
//              starvation override for port 1 after STARVE_MAX denials.
// Revision   : 1.0 - initial release
// ============================================================================
module mem_pic_arb #(
    parameter int SIZE       = 8,
    parameter int STARVE_MAX = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_pic_arb_if.slave  bus
);

    logic            w_grant0;
    logic            w_grant1;
    logic            w_any_grant;
    logic [SIZE-1:0] w_win_addr;

    logic [SIZE-1:0] r_mem_address;
    logic            r_tag_a_valid;
    logic            r_tag_a_port;
    logic            r_tag_b_valid;
    logic            r_tag_b_port;
    logic            r_rsp0_valid;
    logic            r_rsp1_valid;
    logic [SIZE-1:0] r_rsp0_data;
    logic [SIZE-1:0] r_rsp1_data;

`ifdef MEM_PIC_ARB_RR_EN
    // Port granted most recently; on contention the other port wins.
    logic r_last_grant;

    // Round-robin grant selection; nothing is granted while reset is held.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = r_last_grant;
                w_grant1 = !r_last_grant;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end
    end

    // Remember the winner of every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end
`else
    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_force1;

    // Fixed priority to port 0 unless port 1 has been denied STARVE_MAX times.
    always_comb begin
        w_force1 = bus.req1_valid && (r_starve_cnt == STARVE_LIM);
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            w_grant1 = bus.req1_valid && (!bus.req0_valid || w_force1);
            w_grant0 = bus.req0_valid && !w_grant1;
        end
    end

    // Count consecutive port 1 denials, saturating at the override threshold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!bus.req1_valid || w_grant1) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_LIM) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`endif

    assign w_any_grant = w_grant0 || w_grant1;
    assign w_win_addr  = w_grant1 ? bus.req1_addr : bus.req0_addr;

    // Address register and two-stage tag pipe aligned with the memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_address <= '0;
            r_tag_a_valid <= 1'b0;
            r_tag_a_port  <= 1'b0;
            r_tag_b_valid <= 1'b0;
            r_tag_b_port  <= 1'b0;
        end else begin
            if (w_any_grant) begin
                r_mem_address <= w_win_addr;
            end
            r_tag_a_valid <= w_any_grant;
            r_tag_a_port  <= w_grant1;
            r_tag_b_valid <= r_tag_a_valid;
            r_tag_b_port  <= r_tag_a_port;
        end
    end

    // Steer returning memory data to the port named by the oldest tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_rsp0_valid <= r_tag_b_valid && !r_tag_b_port;
            r_rsp1_valid <= r_tag_b_valid &&  r_tag_b_port;
            if (r_tag_b_valid && !r_tag_b_port) begin
                r_rsp0_data <= bus.mem_read;
            end
            if (r_tag_b_valid && r_tag_b_port) begin
                r_rsp1_data <= bus.mem_read;
            end
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.mem_address = r_mem_address;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp0_data   = r_rsp0_data;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp1_data   = r_rsp1_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_pic_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_pic_arb
// Description: Self-checking bench for mem_pic_arb. mem_pic is modelled as a
//              one-cycle synchronous ROM returning addr ^ 8'hA5. Accepted
//              requests push their expected port, data and arrival cycle onto
//              a scoreboard that is drained as responses appear.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_pic_arb;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic g0;
    logic g1;
    logic exp_g1;

    mem_pic_arb_if #(.SIZE(8)) bus ();

    mem_pic_arb #(.SIZE(8), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Cycle counter and mem_pic ROM model.
    always_ff @(posedge clk) begin
        cyc          <= cyc + 1;
        bus.mem_read <= bus.mem_address ^ 8'hA5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare whatever the DUT presented on the response ports this cycle.
    task automatic check_rsp();
        exp_t e;
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            chk("rsp_onehot", {31'b0, bus.rsp0_valid & bus.rsp1_valid}, 32'd0);
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", {31'b0, bus.rsp1_valid}, {31'b0, e.port});
                chk("rsp_data", {24'b0, (bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data)},
                    {24'b0, e.data});
                chk("rsp_cycle", cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("rsp_missing", {30'b0, bus.rsp1_valid, bus.rsp0_valid},
                e.port ? 32'd2 : 32'd1);
        end
    endtask

    // One clock of stimulus: check responses, drive inputs, record grants.
    task automatic tick(input logic rst_v, input logic v0, input logic [7:0] a0,
                        input logic v1, input logic [7:0] a1);
        @(negedge clk);
        check_rsp();
        reset          = rst_v;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        #1;
        g0 = bus.req0_ready;
        g1 = bus.req1_ready;
        chk("ready_onehot", {31'b0, g0 & g1}, 32'd0);
        chk("ready_needs_valid", {31'b0, (g0 & !v0) | (g1 & !v1)}, 32'd0);
        if (g0) sb.push_back('{1'b0, a0 ^ 8'hA5, cyc + 3});
        if (g1) sb.push_back('{1'b1, a1 ^ 8'hA5, cyc + 3});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = 8'h00;

        // Reset held with both requesters active.
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 8'h11, 1'b1, 8'h22);
            chk("rst_ready0", {31'b0, g0}, 32'd0);
            chk("rst_ready1", {31'b0, g1}, 32'd0);
            chk("rst_mem_address", {24'b0, bus.mem_address}, 32'd0);
            chk("rst_rsp_valid", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            chk("rst_rsp_data", {16'b0, bus.rsp1_data, bus.rsp0_data}, 32'd0);
        end
        idle(3);

        // Single port 0 read.
        tick(1'b0, 1'b1, 8'h10, 1'b0, 8'h00);
        chk("single_ready", {31'b0, g0}, 32'd1);
        idle(3);
        chk("single_valid", {31'b0, bus.rsp0_valid}, 32'd1);
        chk("single_data", {24'b0, bus.rsp0_data}, 32'hB5);
        idle(1);
        chk("single_pulse", {31'b0, bus.rsp0_valid}, 32'd0);
        chk("single_hold", {24'b0, bus.rsp0_data}, 32'hB5);

        // Port 1 stream on consecutive cycles.
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 8'(i * 4));
            chk("stream_ready", {31'b0, g1}, 32'd1);
        end
        idle(5);
        chk("stream_drain", sb.size(), 32'd0);

        // Both ports requesting continuously.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 8'h40 + 8'(i), 1'b1, 8'h80 + 8'(i));
`ifdef MEM_PIC_ARB_RR_EN
            exp_g1 = ((i % 2) == 1);
`else
            exp_g1 = ((i % 5) == 4);
`endif
            chk("contend_grant1", {31'b0, g1}, {31'b0, exp_g1});
            chk("contend_grant0", {31'b0, g0}, {31'b0, !exp_g1});
        end
        idle(5);
        chk("contend_drain", sb.size(), 32'd0);

        // Reset while two reads are in flight.
        tick(1'b0, 1'b1, 8'h30, 1'b0, 8'h00);
        chk("flight_ready0", {31'b0, g0}, 32'd1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h31);
        chk("flight_ready1", {31'b0, g1}, 32'd1);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        sb.delete();
        chk("flight_rst_rsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        idle(5);
        chk("flight_no_rsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        tick(1'b0, 1'b1, 8'h08, 1'b0, 8'h00);
        chk("after_rst_ready", {31'b0, g0}, 32'd1);
        idle(3);
        chk("after_rst_valid", {31'b0, bus.rsp0_valid}, 32'd1);
        chk("after_rst_data", {24'b0, bus.rsp0_data}, 32'hAD);
        idle(3);
        chk("final_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
